sum_serializer: RTL and testbench
=================================

SUM_SERIALIZER -- requirements
Module: sum_serializer

Interface
REQ-001 Parameter DATA_W, default 8: width of each sum lane and of out_data.
REQ-002 Parameter CNT_W, default 16: width of frame_cnt.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port sum_one, input, DATA_W: first lane, from the upstream three-lane adder.
REQ-006 Port sum_two, input, DATA_W: second lane.
REQ-007 Port sum_three, input, DATA_W: third lane.
REQ-008 Port in_valid, input, 1: the three sums are valid this cycle.
REQ-009 Port in_ready, output, 1: the block accepts a frame this cycle.
REQ-010 Port out_data, output, DATA_W: serial byte stream.
REQ-011 Port out_valid, output, 1: out_data is valid.
REQ-012 Port out_ready, input, 1: downstream accepts out_data.
REQ-013 Port out_last, output, 1: marks the final byte of a frame.
REQ-014 Port frame_cnt, output, CNT_W: number of frames fully emitted.

Function
REQ-015 A frame is accepted on a cycle with in_valid and in_ready both high; all three lanes are registered on that edge.
REQ-016 The FSM states are IDLE, S_ONE, S_TWO and S_THREE (plus S_CHK when the checksum feature is compiled in).
REQ-017 Transitions: IDLE goes to S_ONE on accept; each S_x goes to the next state on out_valid and out_ready; the final state goes to S_ONE on a same-cycle accept, otherwise to IDLE.
REQ-018 Bytes are emitted in the order sum_one, sum_two, sum_three; the first byte is valid the cycle after accept (latency 1).
REQ-019 out_valid is high in every state except IDLE.
REQ-020 out_data is driven from registers only.
REQ-021 While out_valid is high and out_ready is low, out_data, out_last and the state are held stable.
REQ-022 in_ready is high in IDLE, and high in the final state when out_ready is also high (back-to-back frames with no bubble); it is low otherwise.
REQ-023 in_valid while in_ready is low is ignored; the registered lanes are not overwritten.
REQ-024 out_last is high only in the final state of a frame.
REQ-025 frame_cnt increments by 1 on each accepted last byte and wraps modulo 2^CNT_W with no saturation.
REQ-026 In IDLE, out_data is 0.

Reset
REQ-027 While rst is high, the state is IDLE, the lane registers are 0, out_data is 0, out_valid is 0, out_last is 0, frame_cnt is 0 and in_ready is 0.
REQ-028 After rst is released, in_ready is 1.
REQ-029 Reset asserted mid-frame aborts the frame; the partial frame is not counted and is not resumed.

Configuration
REQ-030 The macro SUM_SERIAL_CHECKSUM_EN controls a checksum byte.
REQ-031 With the macro defined, state S_CHK follows S_THREE and emits sum_one XOR sum_two XOR sum_three; S_CHK is the final state (out_last and the back-to-back accept happen there).
REQ-032 With the macro undefined, S_THREE is the final state and no checksum logic exists.

Structure
REQ-033 Shared package sum_serial_pkg holds the state encoding typedef, the default DATA_W, and the FRAME_LEN constants (3 without the macro, 4 with it).
REQ-034 The block is a single module with no sub-module; the FSM, lane registers and frame counter are inline.

Verification
REQ-035 Scenario 1 (single frame): sums 0x11, 0x22, 0x33 with out_ready held at 1 -> out_data is 0x11, 0x22, 0x33 on cycles 1 to 3, out_last on 0x33, frame_cnt = 1.
REQ-036 Scenario 2 (backpressure): out_ready = 0 for 5 cycles during S_TWO -> out_data holds 0x22 and out_valid stays 1; the sequence completes unchanged.
REQ-037 Scenario 3 (back-to-back): in_valid held at 1 with frames A and B -> B is accepted on the last byte of A, with no idle cycle between A's last byte and B's first byte.
REQ-038 Scenario 4 (ignored input): in_valid pulsed with 0xFF lanes during S_ONE -> ignored; the current frame bytes are unchanged.
REQ-039 Scenario 5 (reset mid-frame): rst asserted in S_TWO -> outputs are 0 immediately (asynchronously), frame_cnt stays at its prior value of 0, and in_ready = 1 after release.
REQ-040 Scenario 6 (checksum, macro defined): sums 0x0F, 0xF0, 0x55 -> fourth byte is 0xAA with out_last set; with CNT_W = 2, after 4 frames frame_cnt wraps to 0.

Source files
------------

// File: rtl/sum_serial_pkg.sv
// Shared types and constants for the three-lane sum serializer.
// SUM_SERIAL_CHECKSUM_EN adds a fourth checksum byte (state S_CHK) to each frame.
package sum_serial_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_CNT_W  = 16;

`ifdef SUM_SERIAL_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_ONE   = 3'd1,
    S_TWO   = 3'd2,
    S_THREE = 3'd3,
    S_CHK   = 3'd4
  } state_e;

  localparam state_e FINAL_STATE = S_CHK;
`else
  localparam int unsigned FRAME_LEN = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_ONE   = 3'd1,
    S_TWO   = 3'd2,
    S_THREE = 3'd3
  } state_e;

  localparam state_e FINAL_STATE = S_THREE;
`endif

  // True for the state that carries out_last and allows a back-to-back accept.
  function automatic logic is_final(input state_e s);
    return s == FINAL_STATE;
  endfunction

endpackage

// File: rtl/sum_serializer.sv
// Serializes three registered sum lanes into a byte stream with valid/ready handshake.
// Define SUM_SERIAL_CHECKSUM_EN to append an XOR checksum byte to every frame.
module sum_serializer
  import sum_serial_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sum_one,
  input  logic [DATA_W-1:0] sum_two,
  input  logic [DATA_W-1:0] sum_three,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] lane_one_q, lane_one_d;
  logic [DATA_W-1:0] lane_two_q, lane_two_d;
  logic [DATA_W-1:0] lane_three_q, lane_three_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic out_hs;
  logic accept;
  logic frame_done;

  assign out_hs = out_valid_q & out_ready;

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign in_ready = ~rst & ((state_q == IDLE) | (is_final(state_q) & out_ready));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_one_q   <= '0;
      lane_two_q   <= '0;
      lane_three_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      lane_one_q   <= lane_one_d;
      lane_two_q   <= lane_two_d;
      lane_three_q <= lane_three_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_one_d   = lane_one_q;
    lane_two_d   = lane_two_q;
    lane_three_d = lane_three_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done   = 1'b0;

    if (accept) begin
      lane_one_d   = sum_one;
      lane_two_d   = sum_two;
      lane_three_d = sum_three;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = S_ONE;
          out_data_d  = sum_one;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
        end
      end
      S_ONE: begin
        // While stalled the output register keeps presenting lane one.
        if (out_hs) begin
          state_d    = S_TWO;
          out_data_d = lane_two_q;
        end else begin
          out_data_d = lane_one_q;
        end
      end
      S_TWO: begin
        if (out_hs) begin
          state_d    = S_THREE;
          out_data_d = lane_three_q;
          out_last_d = is_final(S_THREE);
        end
      end
`ifdef SUM_SERIAL_CHECKSUM_EN
      S_THREE: begin
        if (out_hs) begin
          state_d    = S_CHK;
          out_data_d = lane_one_q ^ lane_two_q ^ lane_three_q;
          out_last_d = 1'b1;
        end
      end
      S_CHK: begin
        frame_done = out_hs;
      end
`else
      S_THREE: begin
        frame_done = out_hs;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Last byte taken: count it, then either restart on a same-cycle accept or go idle.
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      if (accept) begin
        state_d     = S_ONE;
        out_data_d  = sum_one;
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
      end else begin
        state_d     = IDLE;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sum_serializer.sv
// Scoreboard bench for sum_serializer: stimulus queues expected bytes, a monitor pops on handshake.
module tb_sum_serializer;
  import sum_serial_pkg::*;

  localparam int unsigned DW = DEFAULT_DATA_W;
`ifdef SUM_SERIAL_CHECKSUM_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sum_one, sum_two, sum_three;
  logic          in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;
  logic [CW-1:0] frame_cnt;

  logic [DW:0]   sb[$];
  logic [DW:0]   exp_b;
  logic [CW-1:0] exp_cnt = '0;
  logic [CW-1:0] cnt_before;
  logic          acc_on_last;
  int            n_checks = 0;
  int            n_fail   = 0;

  sum_serializer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum_one   (sum_one),
    .sum_two   (sum_two),
    .sum_three (sum_three),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: frame count tracks completed frames; every handshake pops one expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, want no output", out_data);
        end else begin
          exp_b = sb.pop_front();
          check("out_data", 32'(out_data), 32'(exp_b[DW-1:0]));
          check("out_last", 32'(out_last), 32'(exp_b[DW]));
          if (exp_b[DW]) exp_cnt = exp_cnt + CW'(1);
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    int n;
    n = 0;
    sum_one   = a;
    sum_two   = b;
    sum_three = c;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want 1", n);
      in_valid = 1'b0;
    end else begin
      acc_on_last = out_last;
      sb.push_back({1'b0, a});
      sb.push_back({1'b0, b});
`ifdef SUM_SERIAL_CHECKSUM_EN
      sb.push_back({1'b0, c});
      sb.push_back({1'b1, a ^ b ^ c});
`else
      sb.push_back({1'b1, c});
`endif
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_data", 32'(out_data), 32'(a));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes pending, want 0", sb.size());
    end
    @(posedge clk);
    #1;
    check("idle_data", 32'(out_data), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum_one   = '0;
    sum_two   = '0;
    sum_three = '0;
    acc_on_last = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-frame: abort in S_TWO, nothing counted.
    send(8'h11, 8'h22, 8'h33);
    @(posedge clk);
    #1;
    check("s5_in_two", 32'(out_data), 32'h22);
    rst = 1'b1;
    #1;
    check("s5_async_valid", 32'(out_valid), 32'd0);
    check("s5_async_data", 32'(out_data), 32'd0);
    check("s5_async_last", 32'(out_last), 32'd0);
    check("s5_async_in_ready", 32'(in_ready), 32'd0);
    check("s5_frame_cnt", 32'(frame_cnt), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("s5_release_in_ready", 32'(in_ready), 32'd1);
    check("s5_release_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Single frame.
    send(8'h11, 8'h22, 8'h33);
    drain();
    check("s1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Backpressure in S_TWO for five cycles.
    send(8'h11, 8'h22, 8'h33);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("s2_hold_data", 32'(out_data), 32'h22);
      check("s2_hold_valid", 32'(out_valid), 32'd1);
      check("s2_hold_last", 32'(out_last), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back: B accepted on A's last byte, first byte of B follows immediately.
    send(8'hA1, 8'hA2, 8'hA3);
    send(8'hB1, 8'hB2, 8'hB3);
    check("s3_accept_on_last", 32'(acc_on_last), 32'd1);
    drain();

    // Input pulse during S_ONE is ignored.
    send(8'h44, 8'h55, 8'h66);
    out_ready = 1'b0;
    sum_one   = 8'hFF;
    sum_two   = 8'hFF;
    sum_three = 8'hFF;
    in_valid  = 1'b1;
    @(negedge clk);
    check("s4_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("s4_data_kept", 32'(out_data), 32'h44);
    out_ready = 1'b1;
    drain();

`ifdef SUM_SERIAL_CHECKSUM_EN
    // Checksum byte 0x0F^0xF0^0x55 = 0xAA; four frames wrap a 2-bit counter.
    cnt_before = frame_cnt;
    send(8'h0F, 8'hF0, 8'h55);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("s6_chk_byte", 32'(out_data), 32'hAA);
    check("s6_chk_last", 32'(out_last), 32'd1);
    send(8'h01, 8'h02, 8'h03);
    send(8'h10, 8'h20, 8'h30);
    send(8'h0F, 8'hF0, 8'h55);
    drain();
    check("s6_wrap", 32'(frame_cnt), 32'(cnt_before));
`else
    cnt_before = '0;
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
